pin_programmer: RTL and testbench



---
 rtl/pin_programmer_if.sv | 23 ++
 rtl/pin_programmer.sv | 172 +++++++++++++++++
 tb/tb_pin_programmer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pin_programmer_if.sv
// Switch/button/tick inputs and display/PIN outputs of the safe's PIN programmer.
interface pin_programmer_if;
  logic       tick;
  logic       enable;
  logic [3:0] switches;
  logic       save_n;
  logic       action_n;
  logic [4:0] digit1, digit2, digit3, digit4;
  logic [3:0] blink;
  logic [4:0] pin1, pin2, pin3, pin4;
  logic       pin_we;
  logic       busy;

  modport master (
    output tick, enable, switches, save_n, action_n,
    input  digit1, digit2, digit3, digit4, blink, pin1, pin2, pin3, pin4, pin_we, busy
  );

  modport slave (
    input  tick, enable, switches, save_n, action_n,
    output digit1, digit2, digit3, digit4, blink, pin1, pin2, pin3, pin4, pin_we, busy
  );
endinterface

// File: rtl/pin_programmer.sv
// Double-entry PIN programmer: enter a 4-digit PIN twice, commit on match.
// Optional inactivity abort is built when PIN_PROG_TIMEOUT_EN is defined.
module pin_programmer #(
  parameter int DEFAULT_PIN1 = 1,
  parameter int DEFAULT_PIN2 = 2,
  parameter int DEFAULT_PIN3 = 3,
  parameter int DEFAULT_PIN4 = 4,
  parameter int ERR_HOLD     = 3
`ifdef PIN_PROG_TIMEOUT_EN
  , parameter int TIMEOUT    = 10
`endif
) (
  input logic            clock,
  input logic            reset_n,
  pin_programmer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ENTER1, ENTER2, COMMIT, ERROR} state_t;

  state_t          state, state_next;
  logic            save_prev, action_prev;
  logic            save_press, action_press, save_ok, in_entry;
  logic            cmp_pending, match, timeout_hit;
  logic [1:0]      cursor;
  logic [3:0]      cur_bit, blink, err_cnt;
  logic [3:0][4:0] digits, pins;
  logic [3:0][3:0] entry, first_buf;

  assign save_press   = save_prev & ~bus.save_n;
  assign action_press = action_prev & ~bus.action_n;
  assign save_ok      = save_press && (bus.switches <= 4'd9);
  assign in_entry     = (state == ENTER1) || (state == ENTER2);
  assign cur_bit      = 4'b0001 << cursor;
  assign match        = (first_buf == entry);

`ifdef PIN_PROG_TIMEOUT_EN
  logic [7:0] idle_ticks;

  assign timeout_hit = in_entry && !cmp_pending && bus.tick &&
                       (idle_ticks == 8'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset_n)
      idle_ticks <= '0;
    else if (state_next != state && (state_next == ENTER1 || state_next == ENTER2))
      idle_ticks <= '0;
    else if (in_entry && save_press)
      idle_ticks <= '0;
    else if (in_entry && bus.tick)
      idle_ticks <= idle_ticks + 8'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: state_next is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (action_press && bus.enable) state_next = ENTER1;
      ENTER1, ENTER2: begin
        // Cancel and enable loss outrank a pending compare or a simultaneous save.
        if (!bus.enable || action_press)              state_next = IDLE;
        else if (cmp_pending)                         state_next = match ? COMMIT : ERROR;
        else if (timeout_hit)                         state_next = ERROR;
        else if (save_ok && cursor == 2'd3 && state == ENTER1) state_next = ENTER2;
      end
      COMMIT: state_next = IDLE;
      ERROR: begin
        if (!bus.enable)                                       state_next = IDLE;
        else if (bus.tick && err_cnt == 4'(ERR_HOLD - 1))      state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      save_prev   <= 1'b1;
      action_prev <= 1'b1;
      pins        <= {5'(DEFAULT_PIN4), 5'(DEFAULT_PIN3), 5'(DEFAULT_PIN2), 5'(DEFAULT_PIN1)};
      digits      <= '0;
      blink       <= '0;
      cursor      <= '0;
      cmp_pending <= 1'b0;
      err_cnt     <= '0;
      entry       <= '0;
      first_buf   <= '0;
    end else begin
      save_prev   <= bus.save_n;
      action_prev <= bus.action_n;
      case (state)
        IDLE: if (state_next == ENTER1) begin
          digits <= '0;
          blink  <= '0;
          cursor <= '0;
        end
        ENTER1, ENTER2: begin
          if (state_next == IDLE) begin
            digits      <= '0;
            blink       <= '0;
            cursor      <= '0;
            cmp_pending <= 1'b0;
          end else if (state_next == ERROR) begin
            digits      <= {4{5'd15}};
            blink       <= '0;
            err_cnt     <= '0;
            cmp_pending <= 1'b0;
          end else if (cmp_pending) begin
            cmp_pending <= 1'b0;
          end else begin
            if (bus.tick) begin
              digits[cursor] <= {1'b0, bus.switches};
              blink          <= (blink & cur_bit) ^ cur_bit;
            end
            if (save_ok) begin
              entry[cursor]  <= bus.switches;
              digits[cursor] <= {1'b0, bus.switches};
              if (cursor != 2'd3) begin
                cursor <= cursor + 2'd1;
              end else if (state == ENTER1) begin
                first_buf <= {bus.switches, entry[2], entry[1], entry[0]};
                digits    <= '0;
                blink     <= '0;
                cursor    <= '0;
              end else begin
                cmp_pending <= 1'b1;
              end
            end
          end
        end
        COMMIT: begin
          for (int k = 0; k < 4; k++) begin
            pins[k]   <= {1'b0, entry[k]};
            digits[k] <= {1'b0, entry[k]};
          end
          blink  <= '0;
          cursor <= '0;
        end
        ERROR: begin
          if (state_next == IDLE) begin
            digits  <= '0;
            err_cnt <= '0;
            cursor  <= '0;
          end else if (bus.tick) begin
            err_cnt <= err_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.digit1 = digits[0];
  assign bus.digit2 = digits[1];
  assign bus.digit3 = digits[2];
  assign bus.digit4 = digits[3];
  assign bus.blink  = blink;
  assign bus.pin1   = pins[0];
  assign bus.pin2   = pins[1];
  assign bus.pin3   = pins[2];
  assign bus.pin4   = pins[3];
  assign bus.pin_we = (state == COMMIT);
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_pin_programmer.sv
// Directed bench for pin_programmer: commit, mismatch, cancel, enable loss, invalid digit, timeout.
module tb_pin_programmer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   we_count = 0;

  pin_programmer_if bus();

  pin_programmer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (bus.pin_we === 1'b1) we_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] digs();
    return {12'd0, bus.digit4, bus.digit3, bus.digit2, bus.digit1};
  endfunction

  function automatic logic [31:0] pins();
    return {12'd0, bus.pin4, bus.pin3, bus.pin2, bus.pin1};
  endfunction

  function automatic logic [31:0] d4(input int a, input int b, input int c, input int d);
    return {12'd0, 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic do_reset();
    @(negedge clock) reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic press_save(input logic [3:0] v);
    @(negedge clock) begin bus.switches = v; bus.save_n = 1'b0; end
    @(negedge clock) bus.save_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic press_action();
    @(negedge clock) bus.action_n = 1'b0;
    @(negedge clock) bus.action_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse_tick();
    @(negedge clock) bus.tick = 1'b1;
    @(negedge clock) bus.tick = 1'b0;
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press_save(4'(a)); press_save(4'(b)); press_save(4'(c)); press_save(4'(d));
  endtask

  initial begin
    bus.tick = 1'b0; bus.enable = 1'b0; bus.switches = 4'd0;
    bus.save_n = 1'b1; bus.action_n = 1'b1;

    // Reset values
    do_reset();
    check("reset_pins",  pins(), d4(1, 2, 3, 4));
    check("reset_digits", digs(), 32'd0);
    check("reset_busy",  {31'd0, bus.busy}, 32'd0);
    check("reset_we",    {31'd0, bus.pin_we}, 32'd0);
    check("reset_blink", {28'd0, bus.blink}, 32'd0);

    // Matching double entry commits
    bus.enable = 1'b1;
    press_action();
    check("start_busy", {31'd0, bus.busy}, 32'd1);
    press_save(4'd5);
    check("first_digit_shown", digs(), d4(5, 0, 0, 0));
    press_save(4'd6); press_save(4'd7); press_save(4'd8);
    check("enter2_cleared", digs(), 32'd0);
    check("enter2_busy", {31'd0, bus.busy}, 32'd1);
    enter4(5, 6, 7, 8);
    repeat (3) @(negedge clock);
    check("commit_pins",   pins(), d4(5, 6, 7, 8));
    check("commit_digits", digs(), d4(5, 6, 7, 8));
    check("commit_we_once", we_count, 32'd1);
    check("commit_idle",   {31'd0, bus.busy}, 32'd0);

    // Reset mid-entry restores default PIN
    press_action();
    press_save(4'd9);
    do_reset();
    check("midreset_pins", pins(), d4(1, 2, 3, 4));
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_digits", digs(), 32'd0);

    // Mismatch shows dashes for three ticks
    press_action();
    enter4(5, 6, 7, 8);
    enter4(5, 6, 7, 9);
    repeat (2) @(negedge clock);
    check("err_dashes", digs(), d4(15, 15, 15, 15));
    check("err_busy",   {31'd0, bus.busy}, 32'd1);
    pulse_tick(); pulse_tick();
    check("err_hold2",  digs(), d4(15, 15, 15, 15));
    pulse_tick();
    @(negedge clock);
    check("err_done_busy",   {31'd0, bus.busy}, 32'd0);
    check("err_done_digits", digs(), 32'd0);
    check("err_pins",        pins(), d4(1, 2, 3, 4));
    check("err_no_we",       we_count, 32'd1);

    // Enable drop in ENTER2 at cursor 2
    press_action();
    enter4(1, 2, 3, 5);
    press_save(4'd1); press_save(4'd2);
    @(negedge clock) bus.enable = 1'b0;
    @(negedge clock);
    check("endrop_busy",   {31'd0, bus.busy}, 32'd0);
    check("endrop_digits", digs(), 32'd0);
    bus.enable = 1'b1;

    // Action together with save cancels
    press_action();
    press_save(4'd7);
    @(negedge clock) begin bus.switches = 4'd2; bus.save_n = 1'b0; bus.action_n = 1'b0; end
    @(negedge clock) begin bus.save_n = 1'b1; bus.action_n = 1'b1; end
    @(negedge clock);
    check("cancel_busy",   {31'd0, bus.busy}, 32'd0);
    check("cancel_digits", digs(), 32'd0);
    check("cancel_pins",   pins(), d4(1, 2, 3, 4));

    // Invalid digit ignored, blink follows cursor
    press_action();
    press_save(4'd12);
    check("invalid_not_shown", digs(), 32'd0);
    bus.switches = 4'd3;
    pulse_tick();
    check("tick_cursor0", digs(), d4(3, 0, 0, 0));
    check("blink_c0",     {28'd0, bus.blink}, 32'b0001);
    press_save(4'd3);
    bus.switches = 4'd7;
    pulse_tick();
    check("tick_cursor1", digs(), d4(3, 7, 0, 0));
    check("blink_c1_on",  {28'd0, bus.blink}, 32'b0010);
    pulse_tick();
    check("blink_c1_off", {28'd0, bus.blink}, 32'b0000);
    press_save(4'd4);
    check("save_cursor1", digs(), d4(3, 4, 0, 0));

    // Inactivity
    bus.switches = 4'd6;
`ifdef PIN_PROG_TIMEOUT_EN
    repeat (10) pulse_tick();
    @(negedge clock);
    check("timeout_err",  digs(), d4(15, 15, 15, 15));
    check("timeout_busy", {31'd0, bus.busy}, 32'd1);
    repeat (3) pulse_tick();
    @(negedge clock);
    check("timeout_idle", {31'd0, bus.busy}, 32'd0);
`else
    repeat (20) pulse_tick();
    @(negedge clock);
    check("no_timeout_busy",   {31'd0, bus.busy}, 32'd1);
    check("no_timeout_digits", digs(), d4(3, 4, 6, 0));
    press_action();
    check("late_cancel", {31'd0, bus.busy}, 32'd0);
`endif
    check("final_pins", pins(), d4(1, 2, 3, 4));
    check("final_we",   we_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
